// File: rtl/counter_param.sv
// Parametrised up/down/step counter with parallel load and cascade carry.
// Registered rco/load pulses; combinational cout feeds the next stage's cin.
module counter_param #(
    parameter int unsigned     WIDTH    = 32,
    parameter longint unsigned STEP     = 3,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cin,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load,
    output logic             cout
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

    typedef enum logic [1:0] {
        MODE_UP_STEP = 2'b00,
        MODE_DOWN    = 2'b01,
        MODE_UP      = 2'b10,
        MODE_LOAD    = 2'b11
    } mode_t;

    logic           cnt_en;
    logic [WIDTH:0] sum_step;
    logic           wrap;
    mode_t          cur_mode;

    // The mode-00 carry is the top bit of a one-bit-wider sum, which is
    // the same test as Q > all-ones - STEP without a subtraction.
    always_comb begin
        cur_mode = mode_t'(mode);
        cnt_en   = enable & cin;
        sum_step = {1'b0, Q} + {1'b0, STEP_W};
        case (cur_mode)
            MODE_UP_STEP: wrap = sum_step[WIDTH];
            MODE_DOWN:    wrap = (Q == '0);
            MODE_UP:      wrap = (Q == ALL_ONES);
            default:      wrap = 1'b0;
        endcase
    end

    assign cout = cnt_en & wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q    <= '0;
            rco  <= 1'b0;
            load <= 1'b0;
        end else begin
            rco  <= 1'b0;
            load <= 1'b0;
            if (enable) begin
                if (cur_mode == MODE_LOAD) begin
                    Q    <= D;
                    load <= 1'b1;
                end else if (cin) begin
                    rco <= wrap;
                    case (cur_mode)
                        MODE_UP_STEP: Q <= (wrap && SATURATE) ? ALL_ONES : sum_step[WIDTH-1:0];
                        MODE_DOWN:    Q <= wrap ? (SATURATE ? '0 : ALL_ONES) : Q - ONE;
                        default:      Q <= wrap ? (SATURATE ? ALL_ONES : '0) : Q + ONE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_param.sv
// Bench for counter_param: 32-bit wrap and saturate instances plus a
// two-stage 4-bit cascade, checked every cycle against an arithmetic model.
module tb_counter_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cin;
    logic [1:0]  mode;
    logic [31:0] d;

    logic [31:0] q_w, q_s;
    logic        rco_w, load_w, cout_w;
    logic        rco_s, load_s, cout_s;
    logic [3:0]  q_lo, q_hi;
    logic        rco_lo, load_lo, cout_lo;
    logic        rco_hi, load_hi, cout_hi;

    int n_checks = 0;
    int n_fail   = 0;

    longint unsigned m_q = 0, m_qs = 0, m_c = 0;
    bit m_rco = 0, m_rco_s = 0, m_load = 0, m_rco_lo = 0, m_rco_hi = 0;

    always #5 clk = ~clk;

    counter_param #(.WIDTH(32), .STEP(3), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .cin(cin), .mode(mode), .D(d),
        .Q(q_w), .rco(rco_w), .load(load_w), .cout(cout_w)
    );

    counter_param #(.WIDTH(32), .STEP(3), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .cin(cin), .mode(mode), .D(d),
        .Q(q_s), .rco(rco_s), .load(load_s), .cout(cout_s)
    );

    counter_param #(.WIDTH(4), .STEP(1), .SATURATE(1'b0)) dut_lo (
        .clk(clk), .reset(reset), .enable(enable), .cin(cin), .mode(mode), .D(d[3:0]),
        .Q(q_lo), .rco(rco_lo), .load(load_lo), .cout(cout_lo)
    );

    counter_param #(.WIDTH(4), .STEP(1), .SATURATE(1'b0)) dut_hi (
        .clk(clk), .reset(reset), .enable(enable), .cin(cout_lo), .mode(mode), .D(d[3:0]),
        .Q(q_hi), .rco(rco_hi), .load(load_hi), .cout(cout_hi)
    );

    // True when a counting step from q in mode m would cross the bound.
    function automatic bit wrap_hit(input longint unsigned q, input int w,
                                    input longint unsigned step, input logic [1:0] m);
        longint unsigned top = (64'd1 << w) - 1;
        case (m)
            2'b00:   return (q + step > top);
            2'b01:   return (q == 0);
            2'b10:   return (q == top);
            default: return 1'b0;
        endcase
    endfunction

    function automatic longint unsigned next_q(input longint unsigned q, input int w,
                                               input longint unsigned step, input bit sat,
                                               input logic en, input logic c,
                                               input logic [1:0] m, input longint unsigned dv);
        longint unsigned top = (64'd1 << w) - 1;
        if (!en) return q;
        if (m == 2'b11) return dv & top;
        if (!c) return q;
        if (wrap_hit(q, w, step, m)) begin
            case (m)
                2'b00:   return sat ? top : q + step - (top + 1);
                2'b01:   return sat ? 0 : top;
                default: return sat ? top : 0;
            endcase
        end
        case (m)
            2'b00:   return q + step;
            2'b01:   return q - 1;
            default: return q + 1;
        endcase
    endfunction

    // The cascade is modelled as a single 8-bit counter; with STEP=1 every
    // counting mode is a plain +/-1 on the combined value.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q <= 0; m_qs <= 0; m_c <= 0;
            m_rco <= 0; m_rco_s <= 0; m_load <= 0; m_rco_lo <= 0; m_rco_hi <= 0;
        end else begin
            m_q      <= next_q(m_q, 32, 3, 1'b0, enable, cin, mode, longint'(d));
            m_qs     <= next_q(m_qs, 32, 3, 1'b1, enable, cin, mode, longint'(d));
            m_c      <= next_q(m_c, 8, 1, 1'b0, enable, cin, mode, longint'({d[3:0], d[3:0]}));
            m_rco    <= enable & cin & wrap_hit(m_q, 32, 3, mode);
            m_rco_s  <= enable & cin & wrap_hit(m_qs, 32, 3, mode);
            m_rco_lo <= enable & cin & wrap_hit(m_c & 15, 4, 1, mode);
            m_rco_hi <= enable & cin & wrap_hit(m_c, 8, 1, mode);
            m_load   <= enable & (mode == 2'b11);
        end
    end

    task automatic check_output(input string name, input longint unsigned act,
                                input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        check_output("model q_wrap", q_w, m_q);
        check_output("model rco_wrap", rco_w, m_rco);
        check_output("model load_wrap", load_w, m_load);
        check_output("model cout_wrap", cout_w, enable & cin & wrap_hit(m_q, 32, 3, mode));
        check_output("model q_sat", q_s, m_qs);
        check_output("model rco_sat", rco_s, m_rco_s);
        check_output("model load_sat", load_s, m_load);
        check_output("model cout_sat", cout_s, enable & cin & wrap_hit(m_qs, 32, 3, mode));
        check_output("model q_cascade", {q_hi, q_lo}, m_c);
        check_output("model rco_lo", rco_lo, m_rco_lo);
        check_output("model rco_hi", rco_hi, m_rco_hi);
        check_output("model load_lo", load_lo, m_load);
        check_output("model load_hi", load_hi, m_load);
        check_output("model cout_lo", cout_lo, enable & cin & wrap_hit(m_c & 15, 4, 1, mode));
        check_output("model cout_hi", cout_hi, enable & cin & wrap_hit(m_c, 8, 1, mode));
    end

    task automatic apply_stimulus(input logic en, input logic c, input logic [1:0] m,
                                  input logic [31:0] dv);
        @(negedge clk);
        enable = en;
        cin    = c;
        mode   = m;
        d      = dv;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi_rco_seen;
        logic [31:0] rd;
        reset = 1'b0; enable = 1'b0; cin = 1'b0; mode = 2'b00; d = '0;
        repeat (2) @(posedge clk);
        #2;
        check_output("reset q", q_w, 0);
        check_output("reset rco", rco_w, 0);
        check_output("reset load", load_w, 0);
        @(negedge clk);
        reset = 1'b1;

        // Overflow on mode 00 from near the top, wrap and saturate.
        apply_stimulus(1, 1, 2'b11, 32'hFFFF_FFFD);
        check_output("load q", q_w, 32'hFFFF_FFFD);
        check_output("load flag", load_w, 1);
        apply_stimulus(1, 1, 2'b00, 0);
        check_output("step wrap q", q_w, 32'h0000_0000);
        check_output("step wrap rco", rco_w, 1);
        check_output("step wrap load", load_w, 0);
        check_output("step sat q", q_s, 32'hFFFF_FFFF);
        check_output("step sat rco", rco_s, 1);
        apply_stimulus(1, 1, 2'b00, 0);
        check_output("step q", q_w, 32'h0000_0003);
        check_output("step rco", rco_w, 0);
        check_output("sat hold q", q_s, 32'hFFFF_FFFF);
        check_output("sat rco again", rco_s, 1);
        apply_stimulus(1, 1, 2'b01, 0);
        check_output("sat down q", q_s, 32'hFFFF_FFFE);
        check_output("sat down rco", rco_s, 0);

        // Down-count underflow with cout visible while Q==0, then up wrap.
        apply_stimulus(1, 1, 2'b11, 0);
        @(negedge clk);
        mode = 2'b01;
        #1;
        check_output("cout at zero", cout_w, 1);
        @(posedge clk);
        #2;
        check_output("down wrap q", q_w, 32'hFFFF_FFFF);
        check_output("down wrap rco", rco_w, 1);
        check_output("down sat q", q_s, 0);
        apply_stimulus(1, 1, 2'b10, 0);
        check_output("up wrap q", q_w, 0);
        check_output("up wrap rco", rco_w, 1);

        // Holds with enable low or cin low; no load without enable.
        apply_stimulus(1, 1, 2'b11, 7);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 1, 2'b10, 0);
            check_output("enable hold q", q_w, 7);
            check_output("enable hold rco", rco_w, 0);
            check_output("enable hold cout", cout_w, 0);
        end
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 0, 2'b10, 0);
            check_output("cin hold q", q_w, 7);
            check_output("cin hold cout", cout_w, 0);
        end
        apply_stimulus(0, 1, 2'b11, 5);
        check_output("no load q", q_w, 7);
        check_output("no load flag", load_w, 0);

        // Asynchronous clear mid-cycle cancels the in-flight load pulse.
        apply_stimulus(1, 1, 2'b11, 32'h1234);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("async q", q_w, 0);
        check_output("async load", load_w, 0);
        @(negedge clk);
        reset = 1'b1;

        // Cascade behaves as one 8-bit counter.
        apply_stimulus(1, 1, 2'b11, 0);
        hi_rco_seen = 0;
        for (int i = 1; i <= 256; i++) begin
            apply_stimulus(1, 1, 2'b10, 0);
            if (i == 20) check_output("cascade 20", {q_hi, q_lo}, 8'h14);
            if (i < 256 && rco_hi) hi_rco_seen++;
        end
        check_output("cascade hi rco silent", hi_rco_seen, 0);
        check_output("cascade wrap q", {q_hi, q_lo}, 8'h00);
        check_output("cascade wrap rco", rco_hi, 1);

        // Random phase, biased towards the bounds so wraps happen often.
        for (int i = 0; i < 2000; i++) begin
            rd = $urandom;
            if ($urandom_range(3) == 0) rd = 32'hFFFF_FFFF - $urandom_range(4);
            else if ($urandom_range(3) == 0) rd = $urandom_range(4);
            if ($urandom_range(63) == 0) begin
                @(negedge clk);
                #3;
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            apply_stimulus(($urandom_range(7) != 0), ($urandom_range(7) != 0),
                           2'($urandom_range(3)), rd);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_param.md
Name: counter_param

Overview:
- Parametrised successor to the 32-bit mode counter.
- WIDTH and count-by-N step are generics, and wrap vs saturate is a parameter.
- Adds a carry-in enable and a combinational carry-out so instances can be cascaded into wider counters.
- Sits in the same DUT slot and keeps the registered rco/load flags the scoreboard already checks.

Parameters:
- WIDTH, 32, counter/data width in bits; legal range 4..64.
- STEP, 3, increment applied in mode 00; legal range 1..(2^WIDTH)-1.
- SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp at all-ones (up) or zero (down).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- enable  input  1  global enable; 0 = hold.
- cin  input  1  cascade enable for count modes; tie to 1 when standalone.
- mode  input  2  00 up by STEP, 01 down by 1, 10 up by 1, 11 parallel load.
- D  input  WIDTH  parallel load value.
- Q  output  WIDTH  registered count.
- rco  output  1  registered ripple-carry/borrow flag, one-cycle pulse.
- load  output  1  registered flag, high the cycle after a load.
- cout  output  1  combinational cascade carry to the next stage's cin.

Behaviour:
- Reset:
  - reset low asynchronously forces Q=0, rco=0, load=0, regardless of clk.
  - Release is sampled synchronously; the first update is on the first rising clk with reset high.
- Count enable: cnt_en = enable & cin.
  - Load requires only enable.
  - enable=0: Q holds; rco<=0, load<=0.
  - enable=1, cin=0 in modes 00/01/10: Q holds; rco<=0, load<=0.
- Mode 00:
  - Sum computed on WIDTH+1 bits: S = Q + STEP.
  - Overflow when S >= 2^WIDTH → rco<=1.
  - Q <= S[WIDTH-1:0] if SATURATE=0, else all-ones. Otherwise Q<=S, rco<=0.
- Mode 01:
  - Q==0 → rco<=1; Q<=all-ones (wrap) or 0 (saturate).
  - Otherwise Q<=Q-1, rco<=0.
- Mode 10:
  - Q==all-ones → rco<=1; Q<=0 (wrap) or all-ones (saturate).
  - Otherwise Q<=Q+1, rco<=0.
- Mode 11: Q<=D, load<=1, rco<=0. load is 0 in every other case.
- Flag timing:
  - rco and load are single-cycle pulses, registered alongside Q; latency is 1 clk from the sampling edge.
  - In saturate mode rco re-asserts every cycle the counter remains at the bound with the same direction.
- cout:
  - cout = cnt_en & the wrap condition of the current mode: 00: Q > all-ones-STEP; 01: Q==0; 10: Q==all-ones; 11: 0.
  - cout is combinational from Q/mode/enable/cin; there is no path from D.
  - Cascade rule: the upper stage's cin = the lower stage's cout, with enable/mode shared. A two-stage chain of WIDTH=W then behaves as a 2W counter for modes 01/10. Mode 00 cascades only as add-STEP on the low stage with carry 1.
- Mode change takes effect on the next edge; there is no internal state beyond Q/rco/load.
- Reset asserted mid-count clears immediately; rco/load pulses in flight are cancelled.

Test Plan:
- Defaults, reset low for 2 clk → Q=0, rco=0, load=0; assert reset low asynchronously mid-cycle with Q=0x1234 → Q=0 before the next edge.
- mode=11, D=0xFFFFFFFD, then mode=00 for 2 clk → Q=0xFFFFFFFD with load=1; then Q=0x00000000 with rco=1, load=0; then Q=0x00000003 with rco=0.
- Same sequence with SATURATE=1 → Q=0xFFFFFFFF with rco=1; next edge Q stays 0xFFFFFFFF with rco=1; switch to mode 01 → Q=0xFFFFFFFE, rco=0.
- Load 0, then mode=01 → Q=0xFFFFFFFF with rco=1 and cout=1 during the cycle Q==0; mode=10 from 0xFFFFFFFF → Q=0 with rco=1.
- enable=0 or cin=0 for 5 clk in mode 10 from Q=7 → Q stays 7, rco=0, cout=0; enable=0 with mode=11 and D=5 → no load.
- Two WIDTH=4 instances chained cout→cin, mode=10, 20 clk from 0 → combined {Qhi,Qlo} = 0x14, high-stage rco silent. Run 256 clk → combined wraps to 0x00 with high-stage rco=1 on that edge.
